// File: rtl/result_streamer.sv
// result_streamer: captures {seq, e, offset} on a rising done and streams it as a checksummed byte frame
module result_streamer #(
    parameter int         SEQ_WIDTH = 8,
    parameter int         E_WIDTH   = 20,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           i_offset,
    input  logic [SEQ_WIDTH-1:0] i_seq,
    input  logic [E_WIDTH-1:0]   i_e,
    input  logic                 i_done,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_overrun,
    output logic [7:0]           o_frame_cnt
);
    localparam int SB = (SEQ_WIDTH + 7) / 8;
    localparam int EB = (E_WIDTH + 7) / 8;
    localparam int N  = 3 + SB + EB;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_n;
    logic               done_q, start, hs, last;
    logic [IW-1:0]      idx, idx_n;
    logic [7:0]         data_n, chk, chk_n;
    logic [6:0]         sh_off;
    logic [SEQ_WIDTH-1:0] sh_seq;
    logic [E_WIDTH-1:0] sh_e;
    logic [8*N-1:0]     frame;

    assign start   = i_done & ~done_q;
    assign o_valid = state == SEND;
    assign o_busy  = o_valid;
    assign hs      = o_valid & i_ready;
    assign last    = idx == LAST;
    // top byte is the running checksum, so the CHK byte is simply the last slot
    assign frame   = {chk, (8*EB)'(sh_e), (8*SB)'(sh_seq), 1'b0, sh_off, HEADER};

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = o_data;
        chk_n   = chk;
        if (state == IDLE && start) begin
            state_n = SEND;
            idx_n   = '0;
            data_n  = HEADER;
            chk_n   = HEADER;
        end else if (hs && last) begin
            state_n = IDLE;
        end else if (hs) begin
            idx_n   = idx + 1'b1;
            data_n  = frame[{idx_n, 3'b000} +: 8];
            chk_n   = chk ^ data_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            idx         <= '0;
            o_data      <= '0;
            chk         <= '0;
            o_overrun   <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state  <= state_n;
            done_q <= i_done;
            idx    <= idx_n;
            o_data <= data_n;
            chk    <= chk_n;
            if (start && state == SEND) o_overrun <= 1'b1;
            if (hs && last) o_frame_cnt <= o_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) {sh_off, sh_seq, sh_e} <= {i_offset, i_seq, i_e};
    end
endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: default and 13/9-bit streamers checked against a frame-list reference model
module tb_result_streamer;
    logic        clk = 1'b0;
    logic        rst, done, ready;
    logic [6:0]  offset;
    logic [7:0]  seq_a;
    logic [19:0] e_a;
    logic [12:0] seq_b;
    logic [8:0]  e_b;
    logic [7:0]  data [2];
    logic        valid [2];
    logic        busy [2];
    logic        ovr_o [2];
    logic [7:0]  cnt_o [2];

    int          n_checks = 0, n_errors = 0;
    logic [7:0]  fr [2][16];
    int          len [2], pos [2], cnt [2];
    bit          ovr [2];
    bit          dprev, zero, mb, st;
    logic [7:0]  loga [$], logb [$];
    logic [7:0]  t1 [7] = '{8'hA5, 8'h05, 8'h3C, 8'h34, 8'h12, 8'h00, 8'hBA};
    logic [7:0]  t6 [7] = '{8'hA5, 8'h00, 8'hFF, 8'h1F, 8'hFF, 8'h01, 8'hBB};

    always #5 clk = ~clk;

    result_streamer dut_a (
        .clk(clk), .rst(rst), .i_offset(offset), .i_seq(seq_a), .i_e(e_a), .i_done(done),
        .o_data(data[0]), .o_valid(valid[0]), .i_ready(ready), .o_busy(busy[0]),
        .o_overrun(ovr_o[0]), .o_frame_cnt(cnt_o[0])
    );

    result_streamer #(.SEQ_WIDTH(13), .E_WIDTH(9)) dut_b (
        .clk(clk), .rst(rst), .i_offset(offset), .i_seq(seq_b), .i_e(e_b), .i_done(done),
        .o_data(data[1]), .o_valid(valid[1]), .i_ready(ready), .o_busy(busy[1]),
        .o_overrun(ovr_o[1]), .o_frame_cnt(cnt_o[1])
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // whole frame is precomputed as a byte list at the moment the model accepts a start
    task automatic build(int k, logic [6:0] off, logic [31:0] s, logic [31:0] e, int sb, int eb);
        int n = 2;
        logic [7:0] c = 8'h00;
        fr[k][0] = 8'hA5;
        fr[k][1] = {1'b0, off};
        for (int i = 0; i < sb; i++) fr[k][n++] = 8'((s >> (8 * i)) & 32'hFF);
        for (int i = 0; i < eb; i++) fr[k][n++] = 8'((e >> (8 * i)) & 32'hFF);
        for (int i = 0; i < n; i++) c = c ^ fr[k][i];
        fr[k][n] = c;
        len[k] = n + 1;
        pos[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            len[k] = 0; pos[k] = 0; cnt[k] = 0; ovr[k] = 0;
        end
        dprev = 0;
        zero = 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mb = pos[k] < len[k];
            check($sformatf("valid%0d", k), 32'(valid[k]), 32'(mb));
            check($sformatf("busy%0d", k), 32'(busy[k]), 32'(mb));
            if (mb) check($sformatf("data%0d_byte%0d", k, pos[k]), 32'(data[k]), 32'(fr[k][pos[k]]));
            if (zero) check($sformatf("data%0d_rst", k), 32'(data[k]), 32'h0);
            check($sformatf("overrun%0d", k), 32'(ovr_o[k]), 32'(ovr[k]));
            check($sformatf("frame_cnt%0d", k), 32'(cnt_o[k]), 32'(cnt[k] % 256));
        end
        if (valid[0] && ready) loga.push_back(data[0]);
        if (valid[1] && ready) logb.push_back(data[1]);
        st = done && !dprev;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                len[k] = 0; pos[k] = 0; cnt[k] = 0; ovr[k] = 0;
            end else begin
                mb = pos[k] < len[k];
                if (st && mb) ovr[k] = 1;
                if (mb && ready) begin
                    pos[k]++;
                    if (pos[k] == len[k]) cnt[k]++;
                end
                if (st && !mb) begin
                    if (k == 0) build(0, offset, 32'(seq_a), 32'(e_a), 1, 3);
                    else build(1, offset, 32'(seq_b), 32'(e_b), 2, 2);
                end
            end
        end
        zero = rst;
        dprev = rst ? 1'b0 : done;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_log(string tag, int k, logic [7:0] exp [7]);
        int sz = k == 0 ? loga.size() : logb.size();
        check({tag, "_len"}, 32'(sz), 32'd7);
        for (int i = 0; i < 7 && i < sz; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(k == 0 ? loga[i] : logb[i]), 32'(exp[i]));
    endtask

    initial begin
        rst = 1; done = 0; ready = 1; offset = 0;
        seq_a = 0; e_a = 0; seq_b = 0; e_b = 0;
        tick(3);
        rst = 0;
        tick(2);
        offset = 7'h05; seq_a = 8'h3C; e_a = 20'h01234; seq_b = 13'h1FFF; e_b = 9'h1FF;
        loga.delete(); logb.delete();
        done = 1; tick(1); done = 0; tick(12);
        cmp_log("frame1", 0, t1);
        check("frame1_cnt", 32'(cnt_o[0]), 32'd1);
        offset = 7'h00;
        loga.delete(); logb.delete();
        done = 1; tick(1); done = 0; tick(12);
        cmp_log("wide", 1, t6);
        offset = 7'h05; seq_a = 8'h3C; e_a = 20'h01234;
        loga.delete();
        done = 1;
        for (int i = 0; i < 24; i++) begin
            ready = (i % 4 == 0 || i % 4 == 3);
            tick(1);
        end
        ready = 1; done = 0; tick(12);
        cmp_log("stall", 0, t1);
        done = 1; tick(100); done = 0; tick(2);
        check("held_ovr", 32'(ovr_o[0]), 32'd0);
        done = 1; tick(12); done = 0; tick(1);
        done = 1; tick(1); done = 0; tick(3);
        seq_a = 8'h99; done = 1; tick(1); done = 0; tick(12);
        check("pulse_ovr_a", 32'(ovr_o[0]), 32'd1);
        check("pulse_ovr_b", 32'(ovr_o[1]), 32'd1);
        done = 1; tick(1); done = 0; tick(4);
        ready = 0; tick(2);
        rst = 1; done = 1; tick(1);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_data", 32'(data[0]), 32'd0);
        check("rst_ovr", 32'(ovr_o[0]), 32'd0);
        check("rst_cnt", 32'(cnt_o[0]), 32'd0);
        rst = 0; ready = 1; loga.delete(); tick(12);
        check("post_rst_len", 32'(loga.size()), 32'd7);
        if (loga.size() > 0) check("post_rst_hdr", 32'(loga[0]), 32'hA5);
        done = 0; rst = 1; tick(1); rst = 0; tick(1);
        for (int i = 0; i < 256; i++) begin
            offset = 7'($urandom); seq_a = 8'($urandom); e_a = 20'($urandom);
            seq_b = 13'($urandom); e_b = 9'($urandom);
            done = 1; tick(1); done = 0; tick(10);
        end
        check("wrap_a", 32'(cnt_o[0]), 32'd0);
        check("wrap_b", 32'(cnt_o[1]), 32'd0);
        for (int i = 0; i < 3000; i++) begin
            ready = $urandom % 4 != 0;
            if ($urandom % 6 == 0) done = ~done;
            rst = $urandom % 400 == 0;
            offset = 7'($urandom); seq_a = 8'($urandom); e_a = 20'($urandom);
            seq_b = 13'($urandom); e_b = 9'($urandom);
            tick(1);
        end
        rst = 0; done = 0; tick(12);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
